// File: rtl/s38584_ch3_pkg.sv
// rtl/s38584_ch3_pkg.sv - shared types and constants for the s38584 channel-3 slot sequencer
package s38584_ch3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } ch3_state_t;

    localparam int CH3_SLOTS  = 8;
    localparam int CH3_SLOT_W = 2 * CH3_SLOTS;
    localparam int CH3_QUAL_W = 10;

    // qual_vec bit positions, packed MSB first as {g4871 .. g4991}
    localparam int Q_G4871 = 9;
    localparam int Q_G4966 = 8;
    localparam int Q_G4899 = 7;
    localparam int Q_G4944 = 6;
    localparam int Q_G4843 = 5;
    localparam int Q_G4859 = 4;
    localparam int Q_G4849 = 3;
    localparam int Q_G4975 = 2;
    localparam int Q_G4983 = 1;
    localparam int Q_G4991 = 0;

endpackage

// File: rtl/s38584_ch3_qual.sv
// rtl/s38584_ch3_qual.sv - combinational qualify decode for the channel-3 flag
// Ports: qual_vec (in, 10) qualifier inputs; qual_ok (out) qualify result.
module s38584_ch3_qual
    import s38584_ch3_pkg::*;
(
    input  logic [CH3_QUAL_W-1:0] qual_vec,
    output logic                  qual_ok
);

    // The block term vetoes g4871 only for the one pattern 111111000 below it.
    logic block;

    assign block = qual_vec[Q_G4966] & qual_vec[Q_G4899] & qual_vec[Q_G4944]
                 & qual_vec[Q_G4843] & qual_vec[Q_G4859] & qual_vec[Q_G4849]
                 & ~qual_vec[Q_G4975] & ~qual_vec[Q_G4983] & ~qual_vec[Q_G4991];

    assign qual_ok = qual_vec[Q_G4871] & ~block;

endmodule

// File: rtl/s38584_ch3_seq.sv
// rtl/s38584_ch3_seq.sv - channel-3 slot load/scan sequencer and flag register
// Ports: CK clock; RN async active-low reset; en global enable; start begin sequence;
//        sdin serial slot data; keep_in alternate flag source; qual_vec qualifiers;
//        sel slot selector; slot_q slot register; busy not-idle; done end pulse;
//        fire channel flag; perr parity error (only with S38584_CH3_PARITY_EN).
module s38584_ch3_seq
    import s38584_ch3_pkg::*;
#(
    parameter int SLOTS = CH3_SLOTS
)
(
    input  logic                      CK,
    input  logic                      RN,
    input  logic                      en,
    input  logic                      start,
    input  logic                      sdin,
    input  logic                      keep_in,
    input  logic [CH3_QUAL_W-1:0]     qual_vec,
    output logic [$clog2(SLOTS)-1:0]  sel,
    output logic [2*SLOTS-1:0]        slot_q,
    output logic                      busy,
    output logic                      done,
    output logic                      fire
`ifdef S38584_CH3_PARITY_EN
    ,
    output logic                      perr
`endif
);

    localparam int SW    = 2 * SLOTS;
    localparam int SEL_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SW);

    ch3_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SW-1:0]     slot_d;
    logic              hit_q, hit_d;
    logic              fire_q, fire_d;
    logic              qual_ok;
    logic              pair_hit;
`ifdef S38584_CH3_PARITY_EN
    logic              par_phase_q, par_phase_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    s38584_ch3_qual u_qual (
        .qual_vec (qual_vec),
        .qual_ok  (qual_ok)
    );

    // Both bits of the pair addressed by sel; {sel,0}/{sel,1} are 2*sel/2*sel+1.
    assign pair_hit = slot_q[{sel_q, 1'b0}] & slot_q[{sel_q, 1'b1}];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        slot_d  = slot_q;
        hit_d   = hit_q;
        fire_d  = fire_q;
        done    = 1'b0;
`ifdef S38584_CH3_PARITY_EN
        par_phase_d = par_phase_q;
        par_d       = par_q;
        perr_d      = perr_q;
`endif
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        hit_d   = 1'b0;
`ifdef S38584_CH3_PARITY_EN
                        par_phase_d = 1'b0;
`endif
                    end
                end
                LOAD: begin
`ifdef S38584_CH3_PARITY_EN
                    if (par_phase_q) begin
                        // Extra cycle: the trailing serial bit is the parity bit.
                        par_d       = sdin;
                        par_phase_d = 1'b0;
                        state_d     = SCAN;
                        sel_d       = '0;
                    end else begin
                        slot_d = {slot_q[SW-2:0], sdin};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(SW - 1)) begin
                            par_phase_d = 1'b1;
                        end
                    end
`else
                    slot_d = {slot_q[SW-2:0], sdin};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SW - 1)) begin
                        state_d = SCAN;
                        sel_d   = '0;
                    end
`endif
                end
                SCAN: begin
                    hit_d = hit_q | pair_hit;
                    sel_d = sel_q + SEL_W'(1);
                    if (sel_q == SEL_W'(SLOTS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
`ifdef S38584_CH3_PARITY_EN
                    perr_d = (^slot_q) ^ par_q;
                    if (!perr_d) begin
                        fire_d = qual_ok ? ~hit_q : keep_in;
                    end
`else
                    fire_d = qual_ok ? ~hit_q : keep_in;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            slot_q  <= '0;
            hit_q   <= 1'b0;
            fire_q  <= 1'b0;
`ifdef S38584_CH3_PARITY_EN
            par_phase_q <= 1'b0;
            par_q       <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            hit_q   <= hit_d;
            fire_q  <= fire_d;
`ifdef S38584_CH3_PARITY_EN
            par_phase_q <= par_phase_d;
            par_q       <= par_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);
    assign fire = fire_q;
`ifdef S38584_CH3_PARITY_EN
    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_s38584_ch3_seq.sv
// tb/tb_s38584_ch3_seq.sv - self-checking bench for s38584_ch3_seq
module tb_s38584_ch3_seq;

`ifdef S38584_CH3_PARITY_EN
    localparam int LOAD_LEN = 17;
`else
    localparam int LOAD_LEN = 16;
`endif
    localparam int DONE_P = LOAD_LEN + 9;

    logic       CK;
    logic       RN;
    logic       en;
    logic       start;
    logic       sdin;
    logic       keep_in;
    logic [9:0] qual_vec;
    logic [2:0] sel;
    logic [15:0] slot_q;
    logic       busy;
    logic       done;
    logic       fire;
`ifdef S38584_CH3_PARITY_EN
    logic       perr;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    s38584_ch3_seq dut (
        .CK       (CK),
        .RN       (RN),
        .en       (en),
        .start    (start),
        .sdin     (sdin),
        .keep_in  (keep_in),
        .qual_vec (qual_vec),
        .sel      (sel),
        .slot_q   (slot_q),
        .busy     (busy),
        .done     (done),
        .fire     (fire)
`ifdef S38584_CH3_PARITY_EN
        ,
        .perr     (perr)
`endif
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: progress = number of enabled cycles since an accepted start
    // (0 = idle). Outputs are derived from that position in the timeline.
    int         m_prog;
    logic [15:0] m_slot;
    logic       m_par;
    logic       m_fire;
    logic       m_perr;

    function automatic logic any_pair(input logic [15:0] s);
        for (int p = 0; p < 8; p++)
            if (s[2*p] && s[2*p+1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic qual_model(input logic [9:0] q);
        return q[9] && !(q[8:3] == 6'b111111 && q[2:0] == 3'b000);
    endfunction

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_prog <= 0;
            m_slot <= '0;
            m_par  <= 1'b0;
            m_fire <= 1'b0;
            m_perr <= 1'b0;
        end else if (en) begin
            if (m_prog == 0) begin
                if (start) m_prog <= 1;
            end else if (m_prog <= 16) begin
                m_slot <= {m_slot[14:0], sdin};
                m_prog <= m_prog + 1;
            end else if (m_prog <= LOAD_LEN) begin
                m_par  <= sdin;
                m_prog <= m_prog + 1;
            end else if (m_prog < DONE_P) begin
                m_prog <= m_prog + 1;
            end else begin
                m_prog <= 0;
                if (LOAD_LEN == 17 && ((^m_slot) ^ m_par)) begin
                    m_perr <= 1'b1;
                end else begin
                    m_perr <= 1'b0;
                    m_fire <= qual_model(qual_vec) ? !any_pair(m_slot) : keep_in;
                end
            end
        end
    end

    always @(negedge CK) begin
        if (cmp_on) begin
            chk("busy", 32'(busy), 32'(m_prog != 0));
            chk("done", 32'(done), 32'(m_prog == DONE_P && en));
            chk("sel", 32'(sel),
                (m_prog > LOAD_LEN && m_prog < DONE_P) ? 32'(m_prog - LOAD_LEN - 1) : 32'd0);
            chk("slot_q", 32'(slot_q), 32'(m_slot));
            chk("fire", 32'(fire), 32'(m_fire));
`ifdef S38584_CH3_PARITY_EN
            chk("perr", 32'(perr), 32'(m_perr));
`endif
        end
    end

    task automatic step();
        @(posedge CK);
        #2;
    endtask

    // Runs one sequence; lat = cycle offset from the start cycle at which done is seen.
    task automatic run_seq(input logic [15:0] data, input logic [9:0] qv, input logic kp,
                           input bit stall, input int rst_at, input bit hold_start,
                           output int lat);
        int c;
        lat      = -1;
        qual_vec = qv;
        keep_in  = kp;
        en       = 1'b1;
        start    = 1'b1;
        step();
        start = hold_start;
        c = 1;
        while (c < 80) begin
            if (c == rst_at) begin
                RN = 1'b0;
                #1;
                chk("rst_slot", 32'(slot_q), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_sel", 32'(sel), 32'd0);
                RN = 1'b1;
                start = 1'b0;
                step();
                return;
            end
            if (c > 5) start = 1'b0;
            sdin = (c <= 16) ? data[16 - c] : ((c == 17) ? ^data : 1'b0);
            en = !(stall && c >= LOAD_LEN + 4 && c < LOAD_LEN + 8);
            #1;
            if (stall && c == LOAD_LEN + 6) chk("stall_sel", 32'(sel), 32'd3);
            if (done) begin
                lat = c;
                break;
            end
            step();
            c++;
        end
        if (lat < 0) chk("done_timeout", 32'(c), 32'(DONE_P));
        en = 1'b1;
        step();
    endtask

    initial begin
        int lat;
        RN = 1'b1; en = 1'b0; start = 1'b0; sdin = 1'b0; keep_in = 1'b0; qual_vec = '0;
        #1 RN = 1'b0;
        cmp_on = 1;
        step(); step();
        RN = 1'b1;
        en = 1'b1;
        repeat (5) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_fire", 32'(fire), 32'd0);
        chk("idle_slot", 32'(slot_q), 32'd0);
        chk("idle_sel", 32'(sel), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // start with en low is ignored
        en = 1'b0; start = 1'b1;
        step(); step();
        chk("start_no_en", 32'(busy), 32'd0);
        start = 1'b0; en = 1'b1;
        step();

        run_seq(16'h0003, 10'b1000000000, 1'b0, 0, 0, 0, lat);
        chk("lat_0003", 32'(lat), 32'(DONE_P));
        chk("slot_0003", 32'(slot_q), 32'h0003);
        chk("fire_0003", 32'(fire), 32'd0);

        run_seq(16'hAAAA, 10'b1000000000, 1'b0, 0, 0, 1, lat);
        chk("lat_aaaa", 32'(lat), 32'(DONE_P));
        chk("fire_aaaa", 32'(fire), 32'd1);

        run_seq(16'h0003, 10'b0000000000, 1'b1, 0, 0, 0, lat);
        chk("fire_keep1", 32'(fire), 32'd1);

        run_seq(16'h0003, 10'b0000000000, 1'b0, 0, 0, 0, lat);
        chk("fire_keep0", 32'(fire), 32'd0);

        run_seq(16'hAAAA, 10'b1111111000, 1'b0, 0, 0, 0, lat);
        chk("fire_blocked", 32'(fire), 32'd0);

        run_seq(16'hC000, 10'b1111111001, 1'b1, 0, 0, 0, lat);
        chk("fire_pair7", 32'(fire), 32'd0);

        run_seq(16'hAAAA, 10'b1000000000, 1'b0, 1, 0, 0, lat);
        chk("lat_stall", 32'(lat), 32'(DONE_P + 4));
        chk("fire_stall", 32'(fire), 32'd1);

        run_seq(16'h0003, 10'b1000000000, 1'b1, 0, 9, 0, lat);
        chk("fire_after_rst", 32'(fire), 32'd0);
        run_seq(16'h0003, 10'b1000000000, 1'b1, 0, 0, 0, lat);
        chk("lat_after_rst", 32'(lat), 32'(DONE_P));
        chk("fire_post_rst", 32'(fire), 32'd0);

        repeat (3) step();
        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
